// File: rtl/generic_func_pack.sv
// ----------------------------------------------------------------------------
// generic_func_pack
//   Shared helper functions for the FIFO family.
//   ptr_inc(ptr, depth): wrapping pointer increment, depth-1 -> 0. Works for
//   any depth, not only powers of two.
// ----------------------------------------------------------------------------
package generic_func_pack;

    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/avalon_st_if.sv
// ----------------------------------------------------------------------------
// avalon_st_if
//   Avalon-ST style handshake bundle: data, empty, sop, eop, vld, rdy.
//   Modports are named from the FIFO's side of the link:
//     master : FIFO write side (payload and vld in, rdy out)
//     slave  : FIFO read side  (payload and vld out, rdy in)
// ----------------------------------------------------------------------------
interface avalon_st_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int EMPTY_WIDTH = 2
);
    logic [DATA_WIDTH-1:0]  data;
    logic [EMPTY_WIDTH-1:0] empty;
    logic                   sop;
    logic                   eop;
    logic                   vld;
    logic                   rdy;

    modport master (input data, input empty, input sop, input eop, input vld, output rdy);
    modport slave  (output data, output empty, output sop, output eop, output vld, input rdy);
endinterface

// File: rtl/sdp_ram.sv
// ----------------------------------------------------------------------------
// sdp_ram
//   Simple dual-port RAM: one synchronous write port, one combinational read.
//   clk      clock
//   write    write enable
//   wr_addr  write address
//   wr_data  write data
//   rd_addr  read address
//   rd_data  read data (combinational from rd_addr)
// ----------------------------------------------------------------------------
module sdp_ram #(
    parameter  int DATA_WIDTH = 8,
    parameter  int MEM_DEPTH  = 16,
    localparam int ADDR_WIDTH = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (write) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/fifo_pkt.sv
// ----------------------------------------------------------------------------
// fifo_pkt
//   Avalon-ST FIFO of any depth >= 2 with almost-full/almost-empty flags,
//   synchronous flush and optional store-and-forward packet mode.
//   clk           clock
//   rst_n         asynchronous reset, active low
//   flush         synchronous clear of all contents (blocks rdy/vld)
//   write         write side (data, empty, sop, eop, vld in; rdy out)
//   read          read side  (data, empty, sop, eop, vld out; rdy in)
//   fill_level    words stored, 0..FIFO_DEPTH
//   pkt_count     complete packets stored
//   full/empty    fill_level == FIFO_DEPTH / fill_level == 0
//   almost_full   fill_level >= AFULL_THRESH
//   almost_empty  fill_level <= AEMPTY_THRESH
//   oversize      sticky: a packet in PKT_MODE did not fit in the FIFO
// ----------------------------------------------------------------------------
module fifo_pkt
    import generic_func_pack::*;
#(
    parameter  int FIFO_DEPTH    = 16,
    parameter  int PKT_MODE      = 0,
    parameter  int AFULL_THRESH  = FIFO_DEPTH - 2,
    parameter  int AEMPTY_THRESH = 2,
    parameter  int DATA_WIDTH    = 8,
    parameter  int EMPTY_WIDTH   = 2,
    localparam int CNT_W         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    avalon_st_if.master      write,
    avalon_st_if.slave       read,
    output logic [CNT_W-1:0] fill_level,
    output logic [CNT_W-1:0] pkt_count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             oversize
);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int WORD_W = DATA_WIDTH + EMPTY_WIDTH + 2;

    if (FIFO_DEPTH < 2) begin : g_bad_depth
        $error("fifo_pkt: FIFO_DEPTH must be >= 2");
    end
    if (AFULL_THRESH > FIFO_DEPTH) begin : g_bad_afull
        $error("fifo_pkt: AFULL_THRESH must be <= FIFO_DEPTH");
    end
    if (AEMPTY_THRESH >= FIFO_DEPTH) begin : g_bad_aempty
        $error("fifo_pkt: AEMPTY_THRESH must be < FIFO_DEPTH");
    end

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              bypass;
    logic              write_cmd;
    logic              read_cmd;
    logic              pkt_ready;
    logic              deadlock;
    logic              rd_eop;
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] rd_word;

    // Flags come straight from the registered counters.
    assign full         = (fill_level == CNT_W'(FIFO_DEPTH));
    assign empty        = (fill_level == '0);
    assign almost_full  = (fill_level >= CNT_W'(AFULL_THRESH));
    assign almost_empty = (fill_level <= CNT_W'(AEMPTY_THRESH));

    // In packet mode a word may leave only once its packet is complete,
    // unless an oversize packet is being drained through bypass.
    assign pkt_ready = (PKT_MODE == 0) || (pkt_count != '0) || bypass;
    assign deadlock  = (PKT_MODE != 0) && full && (pkt_count == '0);

    assign write.rdy = ~full & ~flush;
    assign read.vld  = ~empty & ~flush & pkt_ready;
    assign write_cmd = write.vld & write.rdy;
    assign read_cmd  = read.vld & read.rdy;

    assign wr_word = {write.data, write.empty, write.sop, write.eop};
    assign {read.data, read.empty, read.sop, read.eop} = rd_word;
    assign rd_eop  = rd_word[0];

    sdp_ram #(
        .DATA_WIDTH (WORD_W),
        .MEM_DEPTH  (FIFO_DEPTH)
    ) u_ram (
        .clk     (clk),
        .write   (write_cmd),
        .wr_addr (wr_ptr),
        .wr_data (wr_word),
        .rd_addr (rd_ptr),
        .rd_data (rd_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            pkt_count  <= '0;
            bypass     <= 1'b0;
            oversize   <= 1'b0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            pkt_count  <= '0;
            bypass     <= 1'b0;
            oversize   <= 1'b0;
        end else begin
            if (write_cmd) begin
                wr_ptr <= PTR_W'(ptr_inc(32'(wr_ptr), FIFO_DEPTH));
            end
            if (read_cmd) begin
                rd_ptr <= PTR_W'(ptr_inc(32'(rd_ptr), FIFO_DEPTH));
            end

            case ({write_cmd, read_cmd})
                2'b10:   fill_level <= fill_level + CNT_W'(1);
                2'b01:   fill_level <= fill_level - CNT_W'(1);
                default: fill_level <= fill_level;
            endcase

            case ({write_cmd & write.eop, read_cmd & rd_eop})
                2'b10:   pkt_count <= pkt_count + CNT_W'(1);
                2'b01:   pkt_count <= pkt_count - CNT_W'(1);
                default: pkt_count <= pkt_count;
            endcase

            // A full FIFO with no complete packet can never make progress;
            // open bypass so the partial packet drains.
            if (deadlock) begin
                bypass   <= 1'b1;
                oversize <= 1'b1;
            end else if (read_cmd && rd_eop) begin
                bypass <= 1'b0;
            end
        end
    end
endmodule
